// File: rtl/alu_div_pkg.sv
// ============================================================================
// Module  : alu_div_pkg
// Brief   : Shared state encoding, iteration count and div_op bit positions
//           for the iterative 32-bit divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    localparam int DIV_ITER      = 32;
    localparam int DIV_OP_SIGNED = 0;
    localparam int DIV_OP_MOD    = 1;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_div.sv
// ============================================================================
// Module  : alu_div
// Brief   : Iterative radix-2 restoring divider (div.w/mod.w/div.wu/mod.wu),
//           one quotient bit per cycle, valid/ready handshakes on both sides.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  div_op,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] div_result
);
    import alu_div_pkg::*;

    div_state_t  r_state;
    div_state_t  w_state_nxt;
    logic [4:0]  r_count;
    logic [31:0] r_quo;
    logic [32:0] r_rem;
    logic [31:0] r_divisor;
    logic        r_q_neg;
    logic        r_r_neg;
    logic        r_mod;
    logic        r_dbz;
    logic        r_out_valid;
    logic [31:0] r_result;

    logic        w_signed;
    logic [33:0] w_shift;
    logic        w_fits;
    logic [32:0] w_diff;
    logic [31:0] w_q_final;
    logic [31:0] w_r_final;
    logic [31:0] w_final;

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign div_result = r_out_valid ? r_result : 32'd0;
    assign w_signed   = div_op[DIV_OP_SIGNED];

    // Restoring step: shift the next dividend bit into the partial remainder
    // and keep the subtraction only when the divisor fits.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_fits  = (w_shift >= {2'b00, r_divisor});
    assign w_diff  = w_shift[32:0] - {1'b0, r_divisor};

    assign w_q_final = r_dbz   ? 32'hFFFF_FFFF : (r_q_neg ? (32'd0 - r_quo) : r_quo);
    assign w_r_final = r_r_neg ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
    assign w_final   = r_mod ? w_r_final : w_q_final;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = ST_CALC;
            ST_CALC: if (r_count == 5'(DIV_ITER - 1)) w_state_nxt = ST_DONE;
            ST_DONE: if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= 5'd0;
            r_quo       <= 32'd0;
            r_rem       <= 33'd0;
            r_divisor   <= 32'd0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_mod       <= 1'b0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
        end else if (flush) begin
            r_count     <= 5'd0;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_quo     <= w_signed ? abs32(div_src1) : div_src1;
                        r_divisor <= w_signed ? abs32(div_src2) : div_src2;
                        r_rem     <= 33'd0;
                        r_q_neg   <= w_signed & (div_src1[31] ^ div_src2[31]);
                        r_r_neg   <= w_signed & div_src1[31];
                        r_mod     <= div_op[DIV_OP_MOD];
                        r_dbz     <= (div_src2 == 32'd0);
                        r_count   <= 5'd0;
                    end
                end
                ST_CALC: begin
                    r_rem   <= w_fits ? w_diff : w_shift[32:0];
                    r_quo   <= {r_quo[30:0], w_fits};
                    r_count <= r_count + 5'd1;
                end
                ST_DONE: begin
                    // Sign correction is registered here, giving the extra
                    // cycle between the last iteration and out_valid.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_result    <= w_final;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_result    <= 32'd0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_result    <= 32'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_div.sv
// ============================================================================
// Module  : tb_alu_div
// Brief   : Directed self-checking bench for alu_div with hand-computed results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_div;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] div_src1 = 32'd0;
    logic [31:0] div_src2 = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] div_result;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_div dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .div_op     (div_op),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .div_result (div_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one operation for a single accepting edge, then scramble inputs.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        div_op   = op;
        div_src1 = a;
        div_src2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        div_op   = 2'($urandom);
        div_src1 = $urandom;
        div_src2 = $urandom;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int n;
        start_op(op, a, b);
        wait_valid(n);
        check({tag, " latency"}, 32'(n), 32'd33);
        check({tag, " result"}, div_result, exp);
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold result"}, div_result, exp);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " consumed valid"}, 32'(out_valid), 32'd0);
        check({tag, " consumed result"}, div_result, 32'd0);
        check({tag, " consumed in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", div_result, 32'd0);

        run_op("s 7/2 div",   2'b01, 32'd7,          32'd2,          32'h0000_0003, 0);
        run_op("s 7/2 mod",   2'b11, 32'd7,          32'd2,          32'h0000_0001, 0);
        run_op("s -7/2 div",  2'b01, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 0);
        run_op("s -7/2 mod",  2'b11, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 0);
        run_op("u F9/2 div",  2'b00, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC, 0);
        run_op("u F9/2 mod",  2'b10, 32'hFFFF_FFF9,  32'd2,          32'h0000_0001, 0);
        run_op("s 7/-2 div",  2'b01, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 0);
        run_op("s 7/-2 mod",  2'b11, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 0);
        run_op("ovf div",     2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 0);
        run_op("ovf mod",     2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 0);
        run_op("dbz s div",   2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF, 0);
        run_op("dbz s mod",   2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678, 0);
        run_op("dbz u div",   2'b00, 32'h8765_4321,  32'd0,          32'hFFFF_FFFF, 0);
        run_op("dbz sneg mod",2'b11, 32'h8765_4321,  32'd0,          32'h8765_4321, 0);
        run_op("hold 100%7",  2'b10, 32'd100,        32'd7,          32'h0000_0002, 5);

        // Flush ten cycles into CALC, then a fresh op must see full latency.
        start_op(2'b00, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        run_op("post-flush 100/7", 2'b00, 32'd100, 32'd7, 32'h0000_000E, 0);

        // Flush together with in_valid in IDLE must not start an operation.
        @(negedge clk);
        div_op   = 2'b00;
        div_src1 = 32'd9;
        div_src2 = 32'd3;
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush+valid in_ready", 32'(in_ready), 32'd1);
        watch_no_valid("flush+valid no result", 40);

        // Reset in DONE with out_ready low.
        start_op(2'b01, 32'd50, 32'd5);
        wait_valid(n);
        check("pre-reset valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset DONE out_valid", 32'(out_valid), 32'd0);
        check("reset DONE in_ready", 32'(in_ready), 32'd1);
        check("reset DONE result", div_result, 32'd0);
        watch_no_valid("reset DONE stale", 5);

        // Reset mid-CALC discards the operation.
        start_op(2'b01, 32'd50, 32'd5);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset CALC in_ready", 32'(in_ready), 32'd1);
        watch_no_valid("reset CALC stale", 40);

        run_op("final 50/5", 2'b01, 32'd50, 32'd5, 32'h0000_000A, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high; ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-004 flush  input  1  cancel any operation in flight (pipeline exception/ertn).
REQ-005 in_valid  input  1  operands and div_op valid this cycle.
REQ-006 in_ready  output  1  divider can accept; high only in IDLE.
REQ-007 div_op  input  2  bit0 = signed (div.w/mod.w) vs unsigned (div.wu/mod.wu); bit1 = return remainder (mod) vs quotient (div).
REQ-008 div_src1  input  32  dividend (rj).
REQ-009 div_src2  input  32  divisor (rk).
REQ-010 out_valid  output  1  div_result valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 div_result  output  32  selected quotient or remainder.

Function
REQ-013 Accept SHALL occur on a rising edge with in_valid & in_ready; operands and div_op are registered then and need not be held afterwards.
REQ-014 FSM SHALL have states IDLE -> CALC (accept) -> DONE (after 32nd iteration) -> IDLE (out_valid & out_ready).
REQ-015 CALC SHALL run a 5-bit counter 0..31, one radix-2 restoring step per cycle on |dividend| and |divisor| (33-bit partial remainder).
REQ-016 Latency: accept at edge T, out_valid SHALL rise after edge T+33 and hold with div_result stable until out_ready sampled high.
REQ-017 in_ready SHALL be low in CALC and DONE; no new accept in the cycle the result is consumed (next accept earliest one cycle later).
REQ-018 Signed mode: quotient negated when operand signs differ; remainder takes sign of dividend; magnitudes from two's-complement absolute values.
REQ-019 Unsigned mode: operands used as-is, no sign correction.
REQ-020 Overflow 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000, remainder 0x00000000.
REQ-021 Divide by zero (any mode) SHALL give quotient 0xFFFFFFFF, remainder = div_src1, after the same 33-cycle latency.
REQ-022 flush SHALL return FSM to IDLE on that edge from any state; out_valid low, in_ready high next cycle; flush with in_valid same cycle SHALL NOT accept.
REQ-023 div_result SHALL be 0 whenever out_valid is low.

Reset
REQ-024 reset SHALL override flush and in_valid; next cycle: state IDLE, counter 0, in_ready 1, out_valid 0, div_result 0x00000000.
REQ-025 reset mid-CALC or in DONE SHALL discard the operation; no stale out_valid afterwards.

Structure
REQ-026 Shared package SHALL hold FSM state encoding (IDLE/CALC/DONE), DIV_ITER = 32, and div_op bit positions (DIV_OP_SIGNED = 0, DIV_OP_MOD = 1).
REQ-027 Single flat module; no sub-module; decode into alu_op/div_op stays in the decode stage.

Verification
REQ-028 Signed 7 / 2, mod=0 then mod=1 -> 0x00000003, then 0x00000001, each out_valid exactly 33 cycles after accept.
REQ-029 Signed 0xFFFFFFF9 / 0x00000002 -> q 0xFFFFFFFD, r 0xFFFFFFFF; unsigned same operands -> q 0x7FFFFFFC, r 0x00000001.
REQ-030 Signed 0x80000000 / 0xFFFFFFFF -> q 0x80000000, r 0; divisor 0 with dividend 0x12345678 -> q 0xFFFFFFFF, r 0x12345678.
REQ-031 out_ready held low 5 cycles in DONE -> out_valid and div_result stable, in_ready low throughout; consumed on 6th cycle.
REQ-032 flush at cycle 10 of CALC, then new accept 100 / 7 unsigned -> no out_valid for the flushed op, result 0x0000000E at 33 cycles.
REQ-033 reset asserted in DONE with out_ready low -> out_valid 0, in_ready 1 next cycle, div_result 0.
